// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch constants
// and the fetch FSM state encoding.
package cpu_pkg;

    localparam int          ADDR_W       = 32;
    localparam int          DATA_W       = 32;
    localparam logic [31:0] HALT_ADDR    = 32'h5C;
    localparam logic [31:0] PC_INCREMENT = 32'd4;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_DRAIN,
        F_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched {instr, pc} words,
// with a single-cycle flush for redirects.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch engine: one outstanding imem read at a time, results
// queued for decode, redirect flush and halt-address stop.
module fetch_unit #(
    parameter int                ADDR_W     = cpu_pkg::ADDR_W,
    parameter int                DATA_W     = cpu_pkg::DATA_W,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] HALT_ADDR  = ADDR_W'(cpu_pkg::HALT_ADDR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_current,
    input  logic [ADDR_W-1:0] pc_next,
    output logic [ADDR_W-1:0] pc_in,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted
);

    import cpu_pkg::*;

    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
    localparam int              EW      = DATA_W + ADDR_W;

    fetch_state_t  state;
    fetch_state_t  state_n;
    logic          latch;
    logic          accept;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [EW-1:0] fifo_head;

    always_comb begin
        state_n = state;
        latch   = 1'b0;
        accept  = 1'b0;
        unique case (state)
            F_IDLE: begin
                // Hold off while a redirect is loading a new PC.
                if (pc_current == HALT_ADDR && !redirect) begin
                    state_n = F_HALT;
                end else if (!redirect && fifo_count < DEPTH_C) begin
                    state_n = F_REQ;
                    latch   = 1'b1;
                end
            end
            F_REQ: begin
                if (imem_ack) begin
                    state_n = F_IDLE;
                    accept  = !redirect;
                end else if (redirect) begin
                    state_n = F_DRAIN;
                end
            end
            F_DRAIN: begin
                if (imem_ack)
                    state_n = F_IDLE;
            end
            F_HALT: begin
                if (redirect && redirect_addr != HALT_ADDR)
                    state_n = F_IDLE;
            end
            default: state_n = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= F_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            state    <= state_n;
            imem_req <= (state_n == F_REQ) || (state_n == F_DRAIN);
            if (latch)
                imem_addr <= pc_current;
        end
    end

    always_comb begin
        pc_in = pc_current;
        if (redirect)
            pc_in = redirect_addr;
        else if (accept)
            pc_in = pc_next;
    end

    fetch_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (accept),
        .push_data ({imem_rdata, imem_addr}),
        .pop       (instr_valid && instr_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_head[ADDR_W +: DATA_W];
    assign instr_pc    = fifo_head[ADDR_W-1:0];
    assign halted      = (state == F_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register and memory models, a
// stream scoreboard, directed corner cases and random traffic.
module tb_fetch_unit;

    localparam logic [31:0] HALT = 32'h5C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_current;
    logic [31:0] pc_next;
    logic [31:0] pc_in;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        halted;

    int total = 0;
    int bad   = 0;
    int lat   = 0;
    bit noise = 1'b0;
    int wcnt  = 0;
    int pops  = 0;
    int nack  = 0;
    logic [31:0] exp_pc   = 32'h0;
    logic [31:0] last_pop = 32'h0;
    logic        req_q    = 1'b0;
    logic        ack_q    = 1'b0;
    logic [31:0] addr_q   = 32'h0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .reset         (rst_n),
        .pc_current    (pc_current),
        .pc_next       (pc_next),
        .pc_in         (pc_in),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .halted        (halted)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Program counter register
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_current <= 32'h0;
        else        pc_current <= pc_in;
    end
    assign pc_next = pc_current + 32'd4;

    // Memory: ack after lat waiting cycles, optional stray acks when idle
    always @(posedge clk) begin
        #1;
        if (imem_req) begin
            if (wcnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = memf(imem_addr);
                wcnt       = 0;
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            wcnt = 0;
            if (noise && $urandom_range(0, 9) == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = $urandom;
            end else begin
                imem_ack = 1'b0;
            end
        end
    end

    // Scoreboard: consumed words must follow program order from the
    // last redirect target, and the PC may only hold, step or jump.
    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            exp_pc = 32'h0;
            req_q  = 1'b0;
        end else begin
            bit ok;
            if (imem_req)
                chk("no req at halt addr", 32'(imem_addr == HALT), 32'd0);
            if (imem_req && req_q && !ack_q)
                chk("imem_addr stable", imem_addr, addr_q);
            if (imem_req && imem_ack) nack++;
            if (redirect) begin
                chk("pc_in redirect", pc_in, redirect_addr);
            end else begin
                ok = (pc_in == pc_current) ||
                     (pc_in == pc_next && imem_req && imem_ack &&
                      imem_addr == pc_current);
                chk("pc_in step", 32'(ok), 32'd1);
            end
            if (instr_valid && instr_ready) begin
                chk("pop pc", instr_pc, exp_pc);
                chk("pop data", instr, memf(instr_pc));
                last_pop = instr_pc;
                exp_pc   = exp_pc + 32'd4;
                pops++;
            end
            if (redirect)
                exp_pc = redirect_addr;
            else if (halted && !instr_valid)
                chk("halt pc", exp_pc, HALT);
            req_q  = imem_req;
            ack_q  = imem_ack;
            addr_q = imem_addr;
        end
    end

    function automatic bit cond(input int w, input logic [31:0] a);
        case (w)
            0:       return imem_req && imem_ack;
            1:       return imem_req;
            2:       return instr_valid;
            3:       return halted;
            4:       return imem_req && imem_addr == a;
            default: return imem_req && imem_addr != a;
        endcase
    endfunction

    task automatic wait_for(input int w, input logic [31:0] a,
                            input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cond(w, a) && n < budget);
        chk({name, " wait"}, 32'(cond(w, a)), 32'd1);
    endtask

    task automatic do_reset(input int l);
        rst_n         = 1'b0;
        lat           = l;
        redirect      = 1'b0;
        redirect_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        bit          ready;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] ipc;
        logic [31:0] pcin;
    } vec_t;

    vec_t tv [10];

    initial begin
        bit any_req;
        int p0;

        tv[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        tv[1] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        tv[2] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h4};
        tv[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h4};
        tv[4] = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'h4};
        tv[5] = '{1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h8};
        tv[6] = '{1'b1, 1'b0, 32'h4, 1'b1, 32'h4, 32'h8};
        tv[7] = '{1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h8};
        tv[8] = '{1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'hC};
        tv[9] = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h8, 32'hC};

        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;

        // Sequential fetch, ack latency 1, cycle by cycle
        instr_ready = 1'b1;
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            instr_ready = tv[i].ready;
            @(negedge clk);
            chk($sformatf("seq req[%0d]", i), 32'(imem_req), 32'(tv[i].req));
            chk($sformatf("seq addr[%0d]", i), imem_addr, tv[i].addr);
            chk($sformatf("seq valid[%0d]", i), 32'(instr_valid),
                32'(tv[i].valid));
            chk($sformatf("seq pc_in[%0d]", i), pc_in, tv[i].pcin);
            if (tv[i].valid) begin
                chk($sformatf("seq ipc[%0d]", i), instr_pc, tv[i].ipc);
                chk($sformatf("seq instr[%0d]", i), instr, memf(tv[i].ipc));
            end
        end

        // Reset asserted while a request is pending
        instr_ready = 1'b0;
        do_reset(8);
        wait_for(4, 32'h4, 60, "rst pend");
        chk("rst pre valid", 32'(instr_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst async req", 32'(imem_req), 32'd0);
        chk("rst async valid", 32'(instr_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("rst req", 32'(imem_req), 32'd0);
        chk("rst valid", 32'(instr_valid), 32'd0);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst addr", imem_addr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst post valid", 32'(instr_valid), 32'd0);

        // Decode stalled: buffer fills, fetch stops, then resumes at 0x8
        instr_ready = 1'b0;
        do_reset(0);
        nack = 0;
        repeat (20) @(negedge clk);
        chk("full fetches", 32'(nack), 32'd2);
        chk("full req", 32'(imem_req), 32'd0);
        chk("full valid", 32'(instr_valid), 32'd1);
        chk("full head", instr_pc, 32'h0);
        @(posedge clk);
        #1 instr_ready = 1'b1;
        wait_for(1, 32'h0, 20, "resume");
        chk("resume addr", imem_addr, 32'h8);

        // Redirect while a request is outstanding
        do_reset(3);
        wait_for(4, 32'h10, 100, "drain pend");
        #1;
        redirect      = 1'b1;
        redirect_addr = 32'h40;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        chk("drain flush", 32'(instr_valid), 32'd0);
        chk("drain req", 32'(imem_req), 32'd1);
        chk("drain addr", imem_addr, 32'h10);
        wait_for(5, 32'h10, 30, "drain next");
        chk("drain next addr", imem_addr, 32'h40);
        wait_for(2, 32'h0, 30, "drain valid");
        chk("drain head", instr_pc, 32'h40);

        // Redirect in the same cycle as the ack
        do_reset(2);
        wait_for(0, 32'h0, 30, "coinc ack");
        #1;
        redirect      = 1'b1;
        redirect_addr = 32'h30;
        #1;
        chk("coinc pc_in", pc_in, 32'h30);
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        chk("coinc no push", 32'(instr_valid), 32'd0);
        wait_for(2, 32'h0, 30, "coinc valid");
        chk("coinc head", instr_pc, 32'h30);

        // Run into the halt address, then redirect out
        do_reset(0);
        wait_for(3, 32'h0, 300, "halt");
        chk("halt flag", 32'(halted), 32'd1);
        any_req = 1'b0;
        repeat (10) begin
            @(negedge clk);
            any_req |= imem_req;
        end
        chk("halt no req", 32'(any_req), 32'd0);
        chk("halt last pop", last_pop, 32'h58);
        chk("halt empty", 32'(instr_valid), 32'd0);
        @(posedge clk);
        #1;
        redirect      = 1'b1;
        redirect_addr = 32'h20;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        chk("unhalt flag", 32'(halted), 32'd0);
        wait_for(1, 32'h0, 20, "unhalt req");
        chk("unhalt addr", imem_addr, 32'h20);

        // Random traffic against the scoreboard
        do_reset(1);
        noise = 1'b1;
        p0    = pops;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (!imem_req)
                lat = $urandom_range(0, 3);
            instr_ready   = ($urandom_range(0, 9) < 7);
            redirect      = ($urandom_range(0, 24) == 0);
            redirect_addr = 32'($urandom_range(0, 31)) << 2;
        end
        @(posedge clk);
        #1;
        redirect = 1'b0;
        noise    = 1'b0;
        chk("random progress", 32'(pops - p0 > 200), 32'd1);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
